argmax_sequencer: RTL
=====================

// Module: argmax_sequencer
// PURPOSE
//  Serial arg-max controller for the network's output layer.
//  - Accepts one score per cycle over a valid/ready stream, one frame = NUM_CLASSES scores.
//  - Tracks the running maximum and its index, then presents the winning class index.
//  - Result is held under a valid/ready handshake.
//  - Replaces the wide parallel comparator tree when scores are produced one neuron at a time.
// PARAMETERS
//  NUM_CLASSES  10  scores per frame; legal range 2..2**IDX_W
//  DATA_W       8   score width, unsigned
//  IDX_W        4   class index width; must be >= clog2(NUM_CLASSES)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a new frame; sampled only in IDLE
//  abort      in   1       drop the current frame; sampled in COLLECT and HOLD
//  in_valid   in   1       score present on in_data
//  in_ready   out  1       controller can take a score
//  in_data    in   DATA_W  score of class cnt, unsigned
//  out_valid  out  1       result available
//  out_ready  in   1       consumer takes the result
//  out_idx    out  IDX_W   winning class index
//  out_max    out  DATA_W  winning score
//  busy       out  1       high in COLLECT or HOLD
// BEHAVIOUR
//  Reset (rst=1 at an edge), from any state:
//  - state=IDLE; cnt=0; in_ready=0; out_valid=0; out_idx=0; out_max=0; busy=0.
//  - Any frame in progress is discarded. No partial result is ever output.
//  FSM (all outputs registered):
//  - IDLE: in_ready=0, out_valid=0. On start=1: cnt<=0, go to COLLECT.
//  - COLLECT: in_ready=1. An accept is in_valid & in_ready.
//    - On accept with cnt==0: best<=in_data, best_idx<=0.
//    - On accept with cnt>0 and in_data > best (strict, unsigned): best<=in_data, best_idx<=cnt.
//    - Equal scores keep the lower index, so the first maximum wins.
//    - Every accept does cnt<=cnt+1.
//    - On accept with cnt==NUM_CLASSES-1: go to HOLD. out_idx and out_max are loaded
//      including this final score. out_valid=1 in the next cycle.
//    - in_valid=0 stalls the frame with no state change; there is no timeout.
//  - HOLD: in_ready=0, out_valid=1. out_idx and out_max stay stable until taken.
//    - On out_ready=1: out_valid<=0, go to IDLE.
//  Timing:
//  - Latency from the last accept to out_valid=1 is 1 cycle.
//  - A frame with no stalls takes NUM_CLASSES+2 cycles from the start edge to out_valid.
//  - After a result is taken, the next start is accepted at the earliest 1 cycle later, once in IDLE.
//  abort=1 in COLLECT or HOLD:
//  - Go to IDLE next cycle. out_valid<=0, cnt<=0.
//  - Any in_data accepted in that same cycle is discarded.
//  - abort has priority over accept and over out_ready.
//  start outside IDLE is ignored. rst has priority over abort and start.
//  cnt is IDX_W bits wide and never exceeds NUM_CLASSES-1, so no wrap-around occurs.
//  out_idx and out_max keep the last result after HOLD exits; only rst clears them.
// TESTING
//  T1: start, scores 3,9,1,7,2,8,0,4,5,6, no stalls -> out_idx=1, out_max=9, out_valid 12 cycles after start.
//  T2: scores 5,200,7,200,1,1,1,1,1,200 -> out_idx=1, out_max=200 (tie resolves to lowest index).
//      All-zero frame -> out_idx=0, out_max=0.
//  T3: random in_valid gaps plus out_ready held low 5 cycles -> in_ready=0 and
//      out_idx/out_max stable while out_valid=1; result identical to the no-stall run.
//  T4: abort after 4 accepts, then a full frame with max 255 at index 9 -> only out_idx=9,
//      out_max=255 emitted; no result for the aborted frame.
//  T5: rst pulsed mid-COLLECT and again in HOLD -> next cycle all outputs equal their reset
//      values; a subsequent frame is correct.
//  T6: start held high during COLLECT and HOLD -> ignored; back-to-back frames each produce
//      exactly one out_valid handshake.

Source files
------------

// File: rtl/argmax_sequencer_if.sv
// rtl/argmax_sequencer_if.sv - score stream in, winning-class result out
//
// Purpose: bundles the two handshakes of the arg-max sequencer.
// Ports (signals):
//   in_valid/in_ready/in_data          score stream, producer -> sequencer
//   out_valid/out_ready/out_idx/out_max result, sequencer -> consumer
// Modports: slave = sequencer side, master = producer/consumer side.
interface argmax_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_max;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_max
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_max
  );
endinterface

// File: rtl/argmax_sequencer.sv
// rtl/argmax_sequencer.sv - serial arg-max controller for the output layer
//
// Purpose: takes NUM_CLASSES unsigned scores one at a time, tracks the running
// maximum and its index, and holds the winning index/score under a handshake.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   begin a frame (IDLE only)
//   abort  in   drop the current frame (COLLECT/HOLD)
//   busy   out  high in COLLECT or HOLD
//   bus    slave modport: score stream in, result (out_idx/out_max) out
module argmax_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  argmax_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              take_new;
  logic [DATA_W-1:0] cand_max;
  logic [IDX_W-1:0]  cand_idx;

  // in_ready_q is only ever set while in COLLECT, so it fully qualifies accepts.
  assign accept   = bus.in_valid & in_ready_q;
  // Strict compare keeps the earlier index on ties; the first score always seeds.
  assign take_new = (cnt_q == '0) || (bus.in_data > best_q);
  assign cand_max = take_new ? bus.in_data : best_q;
  assign cand_idx = take_new ? cnt_q : best_idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_max_d   = out_max_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (start) begin
          cnt_d   = '0;
          state_d = COLLECT;
          busy_d  = 1'b1;
        end
      end

      COLLECT: begin
        if (abort) begin
          state_d     = IDLE;
          cnt_d       = '0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          // First COLLECT cycle raises in_ready; it then stays high until the
          // final score so the stream never sees ready while in HOLD.
          in_ready_d = 1'b1;
          if (accept) begin
            best_d     = cand_max;
            best_idx_d = cand_idx;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_d    = HOLD;
              cnt_d      = '0;
              in_ready_d = 1'b0;
              out_idx_d  = cand_idx;
              out_max_d  = cand_max;
            end
          end
        end
      end

      HOLD: begin
        in_ready_d = 1'b0;
        if (abort) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_max_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_max_q   <= out_max_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_max   = out_max_q;
  assign busy          = busy_q;

endmodule
